// File: rtl/md_pair_pkg.sv
// Shared definitions for the pair exit queue: word geometry, the null sentinel and
// the per-frame sample classification used by the reader.
package md_pair_pkg;

    localparam int PAIR_W    = 227;
    localparam int FRAME_LEN = 16;

    localparam logic [PAIR_W-1:0] NULL_PAIR = {1'b1, {(PAIR_W-1){1'b0}}};

    typedef enum logic [1:0] {
        SMP_IDLE  = 2'd0,
        SMP_EMPTY = 2'd1,
        SMP_PAIR  = 2'd2
    } sample_kind_e;

    function automatic logic is_null_pair(input logic [PAIR_W-1:0] w);
        return w == NULL_PAIR;
    endfunction

endpackage

// File: rtl/pair_exit_reader_if.sv
// Queue-side word/empty inputs and pipeline-side valid/ready/payload of the pair exit reader.
// master: the reader itself; slave: the queue plus force pipeline around it.
interface pair_exit_reader_if #(
    parameter int PAIR_W = md_pair_pkg::PAIR_W
);

    logic [PAIR_W-1:0] in_pair;
    logic              in_qempty;
    logic              out_valid;
    logic              out_ready;
    logic [PAIR_W-2:0] out_pair;

    modport master (
        input  in_pair,
        input  in_qempty,
        input  out_ready,
        output out_valid,
        output out_pair
    );

    modport slave (
        output in_pair,
        output in_qempty,
        output out_ready,
        input  out_valid,
        input  out_pair
    );

endinterface

// File: rtl/pair_reader_buf.sv
// DEPTH-entry first-word-fall-through FIFO holding stripped pair payloads.
// Push and pop may coincide even when full; occupancy is exported as count.
module pair_reader_buf #(
    parameter int W     = 226,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;

    assign pop_ok = pop && (count != '0);

    // Storage carries no reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/pair_exit_reader.sv
// Consumer end of the pair exit queue: samples one word per frame, drops nulls, buffers pairs
// for the force pipeline and reports drops and drain completion. Optional: PAIR_EXIT_READER_STATS_EN.
module pair_exit_reader #(
    parameter int PAIR_W       = md_pair_pkg::PAIR_W,
    parameter int FRAME_LEN    = md_pair_pkg::FRAME_LEN,
    parameter int SAMPLE_PHASE = 1,
    parameter int DEPTH        = 4,
    parameter int DONE_FRAMES  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    pair_exit_reader_if.master            q,
    output logic [$clog2(FRAME_LEN)-1:0]  phase,
    output logic                          drop,
    output logic                          done
`ifdef PAIR_EXIT_READER_STATS_EN
    ,
    output logic [31:0]                   stat_pairs,
    output logic [31:0]                   stat_nulls,
    output logic [15:0]                   stat_drops,
    output logic [$clog2(DEPTH):0]        stat_hiwater
`endif
);

    import md_pair_pkg::*;

    localparam int PH_W  = $clog2(FRAME_LEN);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int EC_W  = $clog2(DONE_FRAMES + 1);

    sample_kind_e        kind_p0;
    logic                sample_p0;
    logic [PAIR_W-2:0]   payload_p0;
    logic                push_req_p0;
    logic                push_p0;
    logic                pop;
    logic                buf_full;
    logic                buf_empty;
    logic [CNT_W-1:0]    count;
    logic [EC_W-1:0]     empty_cnt;

    // A flagged word with any payload bit set is a real pair, not the sentinel.
    function automatic sample_kind_e classify(input logic [PAIR_W-1:0] w, input logic qempty);
        if (qempty || (w[PAIR_W-1] && (w[PAIR_W-2:0] == '0))) begin
            return SMP_EMPTY;
        end
        return SMP_PAIR;
    endfunction

    // Phase counter: reset value lines phase 0 up with the queue presenting a new word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= PH_W'(FRAME_LEN - 1);
        end else begin
            phase <= phase + 1'b1;
        end
    end

    // Sample stage (p0): classify the frame word in the sample cycle.
    assign sample_p0  = (phase == PH_W'(SAMPLE_PHASE));
    assign payload_p0 = q.in_pair[PAIR_W-2:0];

    always_comb begin
        kind_p0 = SMP_IDLE;
        if (sample_p0) begin
            kind_p0 = classify(q.in_pair, q.in_qempty);
        end
    end

    assign buf_empty   = (count == '0);
    assign buf_full    = (count == CNT_W'(DEPTH));
    assign pop         = q.out_valid && q.out_ready;
    assign push_req_p0 = (kind_p0 == SMP_PAIR);
    // A same-cycle pop frees the slot, so fullness only drops when nothing leaves.
    assign drop        = push_req_p0 && buf_full && !pop;
    assign push_p0     = push_req_p0 && !drop;

    // Buffer stage (p1): registered push makes the pair visible one cycle later.
    pair_reader_buf #(
        .W     (PAIR_W - 1),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (push_p0),
        .pop   (pop),
        .din   (payload_p0),
        .dout  (q.out_pair),
        .count (count)
    );

    assign q.out_valid = !buf_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            empty_cnt <= '0;
        end else begin
            case (kind_p0)
                SMP_EMPTY: begin
                    if (empty_cnt != EC_W'(DONE_FRAMES)) begin
                        empty_cnt <= empty_cnt + EC_W'(1);
                    end
                end
                SMP_PAIR: empty_cnt <= '0;
                default:  empty_cnt <= empty_cnt;
            endcase
        end
    end

    assign done = (empty_cnt == EC_W'(DONE_FRAMES)) && buf_empty;

`ifdef PAIR_EXIT_READER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_pairs   <= '0;
            stat_nulls   <= '0;
            stat_drops   <= '0;
            stat_hiwater <= '0;
        end else begin
            if (push_p0 && (stat_pairs != '1)) begin
                stat_pairs <= stat_pairs + 32'd1;
            end
            if ((kind_p0 == SMP_EMPTY) && (stat_nulls != '1)) begin
                stat_nulls <= stat_nulls + 32'd1;
            end
            if (drop && (stat_drops != '1)) begin
                stat_drops <= stat_drops + 16'd1;
            end
            if (count > stat_hiwater) begin
                stat_hiwater <= count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pair_exit_reader.sv
// Bench for pair_exit_reader: a frame-driving queue model plus a scoreboard of expected pairs.
// Build with PAIR_EXIT_READER_STATS_EN defined to also cover the statistics outputs.
module tb_pair_exit_reader;
    import md_pair_pkg::*;

    localparam int PL     = PAIR_W - 1;
    localparam int DEPTH  = 4;
    localparam int SAMPLE = 1;
    localparam int DONE_N = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] phase;
    logic       drop;
    logic       done;
`ifdef PAIR_EXIT_READER_STATS_EN
    logic [31:0] stat_pairs;
    logic [31:0] stat_nulls;
    logic [15:0] stat_drops;
    logic [2:0]  stat_hiwater;
`endif

    always #5 clk = ~clk;

    pair_exit_reader_if #(.PAIR_W(PAIR_W)) qif ();

    pair_exit_reader #(
        .PAIR_W       (PAIR_W),
        .FRAME_LEN    (FRAME_LEN),
        .SAMPLE_PHASE (SAMPLE),
        .DEPTH        (DEPTH),
        .DONE_FRAMES  (DONE_N)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .q            (qif),
        .phase        (phase),
        .drop         (drop),
        .done         (done)
`ifdef PAIR_EXIT_READER_STATS_EN
        ,
        .stat_pairs   (stat_pairs),
        .stat_nulls   (stat_nulls),
        .stat_drops   (stat_drops),
        .stat_hiwater (stat_hiwater)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [PL-1:0] sb_q[$];
    int  tp   = FRAME_LEN - 1;
    int  ecnt = 0;
    bit  mon_en = 1'b0;
    bit  m_full, m_pop, m_exp_drop, m_exp_done;

    function automatic bit word_is_pair(input logic [PAIR_W-1:0] w, input logic qe);
        return !qe && (w !== NULL_PAIR);
    endfunction

    // Reference model of the reader: own phase, own buffer contents, own empty-frame count.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_q.delete();
            tp   = FRAME_LEN - 1;
            ecnt = 0;
        end else begin
            m_full = (sb_q.size() == DEPTH);
            m_pop  = (sb_q.size() != 0) && qif.out_ready;
            if (m_pop) void'(sb_q.pop_front());
            if (tp == SAMPLE) begin
                if (word_is_pair(qif.in_pair, qif.in_qempty)) begin
                    if (!(m_full && !m_pop)) sb_q.push_back(qif.in_pair[PL-1:0]);
                    ecnt = 0;
                end else if (ecnt < DONE_N) begin
                    ecnt = ecnt + 1;
                end
            end
            tp = (tp + 1) % FRAME_LEN;
        end
    end

    // Scoreboard comparison on every active cycle, sampled away from the rising edge.
    always @(negedge clk) begin
        if (mon_en && reset) begin
            m_exp_drop = (tp == SAMPLE) && word_is_pair(qif.in_pair, qif.in_qempty) &&
                         (sb_q.size() == DEPTH) && !qif.out_ready;
            m_exp_done = (ecnt == DONE_N) && (sb_q.size() == 0);
            n_checks++;
            if (qif.out_valid !== (sb_q.size() != 0)) begin
                n_fail++;
                $display("FAIL sb_out_valid t=%0t: got %0b expected %0b", $time, qif.out_valid, sb_q.size() != 0);
            end
            if (sb_q.size() != 0) begin
                n_checks++;
                if (qif.out_pair !== sb_q[0]) begin
                    n_fail++;
                    $display("FAIL sb_out_pair t=%0t: got %h expected %h", $time, qif.out_pair, sb_q[0]);
                end
            end
            n_checks++;
            if (drop !== m_exp_drop) begin
                n_fail++;
                $display("FAIL sb_drop t=%0t: got %0b expected %0b", $time, drop, m_exp_drop);
            end
            n_checks++;
            if (done !== m_exp_done) begin
                n_fail++;
                $display("FAIL sb_done t=%0t: got %0b expected %0b", $time, done, m_exp_done);
            end
            n_checks++;
            if (phase !== 4'(tp)) begin
                n_fail++;
                $display("FAIL sb_phase t=%0t: got %0d expected %0d", $time, phase, tp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic to_frame_start();
        for (int i = 0; i < 32 && tp != 0; i++) tick(1);
    endtask

    // Presents one frame word from phase 0; returns in the sample cycle (phase 1).
    task automatic send_frame(input logic [PAIR_W-1:0] w, input logic qe);
        to_frame_start();
        qif.in_pair   = w;
        qif.in_qempty = qe;
        tick(1);
    endtask

    task automatic test_reset();
        mon_en        = 1'b0;
        reset         = 1'b0;
        qif.in_pair   = NULL_PAIR;
        qif.in_qempty = 1'b1;
        qif.out_ready = 1'b0;
        tick(3);
        n_checks++;
        if (phase !== 4'd15) begin n_fail++; $display("FAIL reset_phase: got %0d expected 15", phase); end
        n_checks++;
        if (qif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", qif.out_valid); end
        n_checks++;
        if (qif.out_pair !== '0) begin n_fail++; $display("FAIL reset_out_pair: got %h expected 0", qif.out_pair); end
        n_checks++;
        if (drop !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_drop_done: got %0b%0b expected 00", drop, done); end
`ifdef PAIR_EXIT_READER_STATS_EN
        n_checks++;
        if (stat_pairs !== 0 || stat_nulls !== 0 || stat_drops !== 0 || stat_hiwater !== 0) begin
            n_fail++;
            $display("FAIL reset_stats: got %0d %0d %0d %0d expected 0 0 0 0", stat_pairs, stat_nulls, stat_drops, stat_hiwater);
        end
`endif
    endtask

    // Release lands before edge 1; phase reaches 1 at edge 2, so the samples register at edges 3 and 19.
    task automatic test_empty_frames();
        int first_done = -1;
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        for (int c = 1; c <= 48; c++) begin
            tick(1);
            if (done === 1'b1 && first_done < 0) first_done = c;
        end
        n_checks++;
        if (first_done != 19) begin n_fail++; $display("FAIL empty_first_done_cycle: got %0d expected 19", first_done); end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL empty_done_held: got %0b expected 1", done); end
    endtask

    task automatic test_pairs();
        logic [PL-1:0] pa1;
        logic [PL-1:0] pa2;
        pa1 = {8'h5A, 210'h0, 8'hA1};
        pa2 = {8'hC3, 210'h0, 8'hA2};
        qif.out_ready = 1'b1;
        send_frame({1'b0, pa1}, 1'b0);
        n_checks++;
        if (qif.out_valid !== 1'b0) begin n_fail++; $display("FAIL pairs_latency: got %0b expected 0", qif.out_valid); end
        tick(1);
        n_checks++;
        if (qif.out_valid !== 1'b1 || qif.out_pair !== pa1) begin
            n_fail++; $display("FAIL pairs_first: got %0b/%h expected 1/%h", qif.out_valid, qif.out_pair, pa1);
        end
        send_frame({1'b0, pa2}, 1'b0);
        tick(1);
        n_checks++;
        if (qif.out_valid !== 1'b1 || qif.out_pair !== pa2) begin
            n_fail++; $display("FAIL pairs_second: got %0b/%h expected 1/%h", qif.out_valid, qif.out_pair, pa2);
        end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL pairs_done: got %0b expected 0", done); end
        send_frame(NULL_PAIR, 1'b1);
    endtask

    task automatic test_overflow();
        int n_drops = 0;
        qif.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send_frame({1'b0, 218'h0, 8'hB0 + 8'(k)}, 1'b0);
            if (drop === 1'b1) n_drops++;
        end
        n_checks++;
        if (n_drops != 1) begin n_fail++; $display("FAIL overflow_drop_count: got %0d expected 1", n_drops); end
        tick(2);
        n_checks++;
        if (qif.out_valid !== 1'b1 || qif.out_pair !== {218'h0, 8'hB0}) begin
            n_fail++; $display("FAIL overflow_head_held: got %0b/%h expected 1/b0", qif.out_valid, qif.out_pair);
        end
`ifdef PAIR_EXIT_READER_STATS_EN
        n_checks++;
        if (stat_drops !== 16'd1 || stat_hiwater !== 3'd4) begin
            n_fail++; $display("FAIL overflow_stats: got drops %0d hiwater %0d expected 1 4", stat_drops, stat_hiwater);
        end
`endif
    endtask

    task automatic test_full_simul_pop();
        logic [PL-1:0] exp_seq [4];
        exp_seq[0] = {218'h0, 8'hB1};
        exp_seq[1] = {218'h0, 8'hB2};
        exp_seq[2] = {218'h0, 8'hB3};
        exp_seq[3] = {218'h0, 8'hC0};
        send_frame({1'b0, 218'h0, 8'hC0}, 1'b0);
        qif.out_ready = 1'b1;
        #1;
        n_checks++;
        if (drop !== 1'b0) begin n_fail++; $display("FAIL simul_pop_drop: got %0b expected 0", drop); end
        tick(1);
        qif.out_ready = 1'b0;
        #1;
        n_checks++;
        if (qif.out_pair !== exp_seq[0]) begin n_fail++; $display("FAIL simul_pop_head: got %h expected %h", qif.out_pair, exp_seq[0]); end
        qif.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (qif.out_valid !== 1'b1 || qif.out_pair !== exp_seq[i]) begin
                n_fail++; $display("FAIL simul_pop_drain%0d: got %0b/%h expected 1/%h", i, qif.out_valid, qif.out_pair, exp_seq[i]);
            end
            tick(1);
        end
        n_checks++;
        if (qif.out_valid !== 1'b0) begin n_fail++; $display("FAIL simul_pop_empty: got %0b expected 0", qif.out_valid); end
    endtask

    task automatic test_flag_words();
        logic [PL-1:0] one;
        one = PL'(1);
        qif.out_ready = 1'b1;
        send_frame({1'b1, one}, 1'b0);
        tick(1);
        n_checks++;
        if (qif.out_valid !== 1'b1 || qif.out_pair !== one) begin
            n_fail++; $display("FAIL flag_nonzero_payload: got %0b/%h expected 1/1", qif.out_valid, qif.out_pair);
        end
        send_frame({1'b0, {PL{1'b0}}}, 1'b0);
        tick(1);
        n_checks++;
        if (qif.out_valid !== 1'b1 || qif.out_pair !== '0) begin
            n_fail++; $display("FAIL flag_zero_pair: got %0b/%h expected 1/0", qif.out_valid, qif.out_pair);
        end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL flag_done: got %0b expected 0", done); end
        send_frame(NULL_PAIR, 1'b0);
    endtask

    task automatic test_reset_mid();
        qif.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) send_frame({1'b0, 218'h0, 8'hD0 + 8'(k)}, 1'b0);
        tick(4);
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if (qif.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_out_valid: got %0b expected 0", qif.out_valid); end
        n_checks++;
        if (phase !== 4'd15) begin n_fail++; $display("FAIL mid_reset_phase: got %0d expected 15", phase); end
        n_checks++;
        if (done !== 1'b0 || qif.out_pair !== '0) begin
            n_fail++; $display("FAIL mid_reset_done_pair: got %0b/%h expected 0/0", done, qif.out_pair);
        end
`ifdef PAIR_EXIT_READER_STATS_EN
        n_checks++;
        if (stat_pairs !== 0 || stat_nulls !== 0 || stat_drops !== 0 || stat_hiwater !== 0) begin
            n_fail++; $display("FAIL mid_reset_stats: got %0d %0d %0d %0d expected 0 0 0 0", stat_pairs, stat_nulls, stat_drops, stat_hiwater);
        end
`endif
        tick(2);
        @(negedge clk);
        reset = 1'b1;
        qif.out_ready = 1'b1;
        send_frame({1'b0, 218'h0, 8'hE0}, 1'b0);
        tick(1);
        n_checks++;
        if (qif.out_valid !== 1'b1 || qif.out_pair !== {218'h0, 8'hE0}) begin
            n_fail++; $display("FAIL post_reset_pair: got %0b/%h expected 1/e0", qif.out_valid, qif.out_pair);
        end
        tick(20);
    endtask

    initial begin
        test_reset();
        test_empty_frames();
        test_pairs();
        test_overflow();
        test_full_simul_pop();
        test_flag_words();
        test_reset_mid();
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule
